// File: rtl/key_edit_pkg.sv
// Shared constants, mode encoding and field helpers for the alarm clock key/menu controller.
package key_edit_pkg;

  localparam int unsigned KEY_W    = 5;
  localparam int unsigned KEY_MENU   = 4;
  localparam int unsigned KEY_SET    = 3;
  localparam int unsigned KEY_CANCEL = 2;
  localparam int unsigned KEY_UP     = 1;
  localparam int unsigned KEY_DOWN   = 0;

  localparam int unsigned TIME_W   = 17;
  localparam int unsigned HOUR_LSB = 12;
  localparam int unsigned MIN_LSB  = 6;
  localparam int unsigned SEC_LSB  = 0;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  typedef enum logic [2:0] {
    ViewTime  = 3'd0,
    ViewAlarm = 3'd1,
    EditHour  = 3'd2,
    EditMin   = 3'd3,
    EditSec   = 3'd4
  } mode_e;

  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Out-of-range values step to 0 going up and to max going down.
  function automatic logic [5:0] wrap_step(logic [5:0] v, logic [5:0] max, logic up);
    if (up) begin
      return (v >= max) ? 6'd0 : v + 6'd1;
    end
    return (v == 6'd0 || v > max) ? max : v - 6'd1;
  endfunction

  function automatic logic [TIME_W-1:0] step_field(logic [TIME_W-1:0] t, mode_e m, logic up);
    logic [TIME_W-1:0] r;
    logic [5:0]        f;
    r = t;
    f = '0;
    case (m)
      EditHour: begin
        f = wrap_step({1'b0, t[HOUR_LSB +: 5]}, HOUR_MAX, up);
        r[HOUR_LSB +: 5] = f[4:0];
      end
      EditMin: begin
        f = wrap_step(t[MIN_LSB +: 6], MIN_MAX, up);
        r[MIN_LSB +: 6] = f;
      end
      EditSec: begin
        f = wrap_step(t[SEC_LSB +: 6], SEC_MAX, up);
        r[SEC_LSB +: 6] = f;
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic mode_e next_field(mode_e m);
    case (m)
      EditHour: return EditMin;
      EditMin:  return EditSec;
      default:  return EditHour;
    endcase
  endfunction

endpackage

// File: rtl/key_edit_ctrl_if.sv
// Key/time inputs and menu/edit outputs of the key controller, bundled with directional views.
interface key_edit_ctrl_if #(
  parameter int unsigned NUM_ALARMS = 4
) ();

  localparam int unsigned AW = key_edit_pkg::idx_width(NUM_ALARMS);

  logic [4:0]               KEY;
  logic [16:0]              IN_TIME;
  logic [17*NUM_ALARMS-1:0] IN_ALARM;
  logic [2:0]               MODE;
  logic [AW-1:0]            ALM_IDX;
  logic                     EDIT_TGT;
  logic [16:0]              OUT_EDIT;
  logic                     COMMIT;
  logic                     TIMEOUT;
  logic [NUM_ALARMS-1:0]    ALARM_EN;

  modport master (
    output KEY, IN_TIME, IN_ALARM,
    input  MODE, ALM_IDX, EDIT_TGT, OUT_EDIT, COMMIT, TIMEOUT, ALARM_EN
  );

  modport slave (
    input  KEY, IN_TIME, IN_ALARM,
    output MODE, ALM_IDX, EDIT_TGT, OUT_EDIT, COMMIT, TIMEOUT, ALARM_EN
  );

endinterface

// File: rtl/key_event.sv
// Key press edge detector; with KEY_AUTOREPEAT_EN defined, held UP/DOWN also auto-repeats.
module key_event
  import key_edit_pkg::*;
#(
  parameter int unsigned REPEAT_DLY  = 50,
  parameter int unsigned REPEAT_RATE = 10
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [4:0] key,
  output logic [4:0] ev
);

  if (REPEAT_DLY == 0 || REPEAT_RATE == 0) begin : g_cfg_check
    $error("key_event: REPEAT_DLY and REPEAT_RATE must be nonzero");
  end

  logic [4:0] key_d_q;
  logic       press;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      key_d_q <= '0;
    end else begin
      key_d_q <= key;
    end
  end

  // A multi-hot chord keeps key_d_q nonzero, so nothing fires until all keys are released.
  assign press = $onehot(key) && (key_d_q == '0);

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned MaxCnt = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int unsigned CW     = $clog2(MaxCnt + 1);

  logic          rpt_act_q;
  logic [CW-1:0] rpt_cnt_q;
  logic          held;
  logic          fire;

  assign held = rpt_act_q && (key == key_d_q);
  assign fire = held && (rpt_cnt_q == '0);

  // Down-counter reaches zero exactly on the repeat edges.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      rpt_act_q <= 1'b0;
      rpt_cnt_q <= '0;
    end else if (press && (key[KEY_UP] || key[KEY_DOWN])) begin
      rpt_act_q <= 1'b1;
      rpt_cnt_q <= CW'(REPEAT_DLY - 1);
    end else if (held) begin
      rpt_cnt_q <= fire ? CW'(REPEAT_RATE - 1) : rpt_cnt_q - 1'b1;
    end else begin
      rpt_act_q <= 1'b0;
    end
  end

  assign ev = (press || fire) ? key : '0;
`else
  assign ev = press ? key : '0;
`endif

endmodule

// File: rtl/key_edit_ctrl.sv
// View/edit menu controller for time and NUM_ALARMS alarms; KEY_AUTOREPEAT_EN enables UP/DOWN
// auto-repeat in the key event stage.
module key_edit_ctrl
  import key_edit_pkg::*;
#(
  parameter int unsigned NUM_ALARMS  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter int unsigned REPEAT_DLY  = 50,
  parameter int unsigned REPEAT_RATE = 10
) (
  input logic            CLK,
  input logic            RESETN,
  key_edit_ctrl_if.slave bus
);

  localparam int unsigned AW = idx_width(NUM_ALARMS);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [AW-1:0] LastIdx = AW'(NUM_ALARMS - 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYC - 1);

  if (NUM_ALARMS < 1 || TIMEOUT_CYC < 2) begin : g_cfg_check
    $error("key_edit_ctrl: need NUM_ALARMS >= 1 and TIMEOUT_CYC >= 2");
  end

  mode_e                 mode_q;
  logic [AW-1:0]         alm_idx_q;
  logic                  edit_tgt_q;
  logic [TIME_W-1:0]     edit_q;
  logic                  commit_q;
  logic                  timeout_q;
  logic [NUM_ALARMS-1:0] alarm_en_q;
  logic [TW-1:0]         tmo_cnt_q;

  logic [4:0]        ev;
  logic              expire;
  logic [TIME_W-1:0] sel_alarm;
  mode_e             ret_mode;

  key_event #(
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_key_event (
    .CLK    (CLK),
    .RESETN (RESETN),
    .key    (bus.KEY),
    .ev     (ev)
  );

  always_comb begin
    sel_alarm = bus.IN_ALARM[TIME_W*alm_idx_q +: TIME_W];
    ret_mode  = edit_tgt_q ? ViewAlarm : ViewTime;
    // Any key activity (even one producing no event) holds the timeout off.
    expire    = (mode_q != ViewTime) && (tmo_cnt_q == TmoLast) && (bus.KEY == '0);
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      mode_q     <= ViewTime;
      alm_idx_q  <= '0;
      edit_tgt_q <= 1'b0;
      edit_q     <= '0;
      commit_q   <= 1'b0;
      timeout_q  <= 1'b0;
      alarm_en_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      commit_q  <= 1'b0;
      timeout_q <= 1'b0;

      // Every state change is caused by a key or by expiry, so this also clears on entry.
      if (mode_q == ViewTime || bus.KEY != '0) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      if (expire) begin
        mode_q    <= ViewTime;
        timeout_q <= 1'b1;
      end else begin
        unique case (mode_q)
          ViewTime: begin
            if (ev[KEY_MENU]) begin
              mode_q    <= ViewAlarm;
              alm_idx_q <= '0;
            end else if (ev[KEY_SET]) begin
              edit_q     <= bus.IN_TIME;
              edit_tgt_q <= 1'b0;
              mode_q     <= EditHour;
            end
          end
          ViewAlarm: begin
            if (ev[KEY_UP]) begin
              alm_idx_q <= (alm_idx_q == LastIdx) ? '0 : alm_idx_q + 1'b1;
            end else if (ev[KEY_DOWN]) begin
              alm_idx_q <= (alm_idx_q == '0) ? LastIdx : alm_idx_q - 1'b1;
            end else if (ev[KEY_CANCEL]) begin
              alarm_en_q[alm_idx_q] <= ~alarm_en_q[alm_idx_q];
            end else if (ev[KEY_SET]) begin
              edit_q     <= sel_alarm;
              edit_tgt_q <= 1'b1;
              mode_q     <= EditHour;
            end else if (ev[KEY_MENU]) begin
              mode_q <= ViewTime;
            end
          end
          EditHour, EditMin, EditSec: begin
            if (ev[KEY_MENU]) begin
              mode_q <= next_field(mode_q);
            end else if (ev[KEY_UP]) begin
              edit_q <= step_field(edit_q, mode_q, 1'b1);
            end else if (ev[KEY_DOWN]) begin
              edit_q <= step_field(edit_q, mode_q, 1'b0);
            end else if (ev[KEY_SET]) begin
              commit_q <= 1'b1;
              if (edit_tgt_q) begin
                alarm_en_q[alm_idx_q] <= 1'b1;
              end
              mode_q <= ret_mode;
            end else if (ev[KEY_CANCEL]) begin
              mode_q <= ret_mode;
            end
          end
          default: mode_q <= ViewTime;
        endcase
      end
    end
  end

  assign bus.MODE     = mode_q;
  assign bus.ALM_IDX  = alm_idx_q;
  assign bus.EDIT_TGT = edit_tgt_q;
  assign bus.OUT_EDIT = edit_q;
  assign bus.COMMIT   = commit_q;
  assign bus.TIMEOUT  = timeout_q;
  assign bus.ALARM_EN = alarm_en_q;

endmodule

// File: tb/tb_key_edit_ctrl.sv
// Directed bench for key_edit_ctrl with hand-computed expectations.
module tb_key_edit_ctrl;

  localparam logic [4:0] K_MENU   = 5'b10000;
  localparam logic [4:0] K_SET    = 5'b01000;
  localparam logic [4:0] K_CANCEL = 5'b00100;
  localparam logic [4:0] K_UP     = 5'b00010;
  localparam logic [4:0] K_DOWN   = 5'b00001;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  key_edit_ctrl_if #(.NUM_ALARMS(4)) bus ();

  key_edit_ctrl #(
    .NUM_ALARMS  (4),
    .TIMEOUT_CYC (1000),
    .REPEAT_DLY  (50),
    .REPEAT_RATE (10)
  ) dut (
    .CLK    (clk),
    .RESETN (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] tm(int h, int m, int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // KEY sampled high on exactly one rising edge; returns just after that edge.
  task automatic press(input logic [4:0] k);
    @(negedge clk);
    bus.KEY = k;
    @(negedge clk);
    bus.KEY = 5'b0;
  endtask

  initial begin
    int exp_sec;
    bus.KEY      = 5'b0;
    bus.IN_TIME  = tm(10, 20, 30);
    bus.IN_ALARM = {tm(22, 59, 59), tm(7, 45, 15), tm(6, 30, 0), tm(6, 0, 0)};
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    check("rst_mode", 32'(bus.MODE), 0);
    check("rst_idx", 32'(bus.ALM_IDX), 0);
    check("rst_tgt", 32'(bus.EDIT_TGT), 0);
    check("rst_edit", 32'(bus.OUT_EDIT), 0);
    check("rst_commit", 32'(bus.COMMIT), 0);
    check("rst_timeout", 32'(bus.TIMEOUT), 0);
    check("rst_alarm_en", 32'(bus.ALARM_EN), 0);

    // Edit time hour 10 -> 13 and commit
    press(K_SET);
    check("t1_mode_edit", 32'(bus.MODE), 2);
    check("t1_load", 32'(bus.OUT_EDIT), 32'(tm(10, 20, 30)));
    repeat (3) press(K_UP);
    press(K_SET);
    check("t1_commit", 32'(bus.COMMIT), 1);
    check("t1_edit", 32'(bus.OUT_EDIT), 32'(tm(13, 20, 30)));
    check("t1_tgt", 32'(bus.EDIT_TGT), 0);
    check("t1_mode_back", 32'(bus.MODE), 0);
    @(negedge clk);
    check("t1_commit_1cyc", 32'(bus.COMMIT), 0);

    // Field wrap
    bus.IN_TIME = tm(0, 59, 7);
    press(K_SET);
    press(K_DOWN);
    check("t2_hour_wrap", 32'(bus.OUT_EDIT), 32'(tm(23, 59, 7)));
    press(K_MENU);
    check("t2_mode_min", 32'(bus.MODE), 3);
    press(K_UP);
    check("t2_min_wrap", 32'(bus.OUT_EDIT), 32'(tm(23, 0, 7)));
    press(K_MENU);
    check("t2_mode_sec", 32'(bus.MODE), 4);
    press(K_MENU);
    check("t2_mode_hour", 32'(bus.MODE), 2);
    press(K_CANCEL);
    check("t2_cancel_mode", 32'(bus.MODE), 0);
    check("t2_cancel_commit", 32'(bus.COMMIT), 0);

    // Out-of-range hour
    bus.IN_TIME = tm(30, 10, 10);
    press(K_SET);
    press(K_UP);
    check("t2_oor_up", 32'(bus.OUT_EDIT), 32'(tm(0, 10, 10)));
    press(K_CANCEL);
    press(K_SET);
    press(K_DOWN);
    check("t2_oor_down", 32'(bus.OUT_EDIT), 32'(tm(23, 10, 10)));
    press(K_CANCEL);

    // Alarm view, index wrap, enable toggle
    press(K_MENU);
    check("t3_mode", 32'(bus.MODE), 1);
    check("t3_idx0", 32'(bus.ALM_IDX), 0);
    press(K_DOWN);
    check("t3_idx_wrap_dn", 32'(bus.ALM_IDX), 3);
    press(K_CANCEL);
    check("t3_en_on", 32'(bus.ALARM_EN), 32'h8);
    press(K_CANCEL);
    check("t3_en_off", 32'(bus.ALARM_EN), 0);
    press(K_UP);
    check("t3_idx_wrap_up", 32'(bus.ALM_IDX), 0);

    // Alarm edit: cancel, then commit
    press(K_UP);
    press(K_UP);
    check("t4_idx2", 32'(bus.ALM_IDX), 2);
    press(K_SET);
    check("t4_mode", 32'(bus.MODE), 2);
    check("t4_tgt", 32'(bus.EDIT_TGT), 1);
    check("t4_load", 32'(bus.OUT_EDIT), 32'(tm(7, 45, 15)));
    press(K_UP);
    check("t4_inc", 32'(bus.OUT_EDIT), 32'(tm(8, 45, 15)));
    press(K_CANCEL);
    check("t4_cancel_commit", 32'(bus.COMMIT), 0);
    check("t4_cancel_mode", 32'(bus.MODE), 1);
    check("t4_cancel_en", 32'(bus.ALARM_EN), 0);
    press(K_SET);
    press(K_MENU);
    press(K_UP);
    press(K_SET);
    check("t4_commit", 32'(bus.COMMIT), 1);
    check("t4_commit_val", 32'(bus.OUT_EDIT), 32'(tm(7, 46, 15)));
    check("t4_commit_en", 32'(bus.ALARM_EN), 32'h4);
    check("t4_commit_mode", 32'(bus.MODE), 1);
    press(K_MENU);
    check("t4_back_time", 32'(bus.MODE), 0);

    // Timeout after 1000 idle cycles
    bus.IN_TIME = tm(10, 20, 30);
    press(K_SET);
    repeat (999) @(negedge clk);
    check("t5_before_tmo", 32'(bus.TIMEOUT), 0);
    check("t5_before_mode", 32'(bus.MODE), 2);
    @(negedge clk);
    check("t5_tmo", 32'(bus.TIMEOUT), 1);
    check("t5_tmo_mode", 32'(bus.MODE), 0);
    check("t5_tmo_idx", 32'(bus.ALM_IDX), 2);
    check("t5_tmo_commit", 32'(bus.COMMIT), 0);
    @(negedge clk);
    check("t5_tmo_1cyc", 32'(bus.TIMEOUT), 0);

    // Key on the expiry edge wins
    press(K_SET);
    repeat (999) @(negedge clk);
    bus.KEY = K_UP;
    @(negedge clk);
    bus.KEY = 5'b0;
    check("t5_key_wins_tmo", 32'(bus.TIMEOUT), 0);
    check("t5_key_wins_mode", 32'(bus.MODE), 2);
    check("t5_key_wins_val", 32'(bus.OUT_EDIT), 32'(tm(11, 20, 30)));
    @(negedge clk);
    check("t5_key_wins_after", 32'(bus.TIMEOUT), 0);
    press(K_CANCEL);

    // Held UP in EDIT_SEC, then a chord
    bus.IN_TIME = tm(10, 20, 0);
    press(K_SET);
    press(K_MENU);
    press(K_MENU);
    check("t6_mode_sec", 32'(bus.MODE), 4);
    @(negedge clk);
    bus.KEY = K_UP;
    repeat (80) @(negedge clk);
    bus.KEY = 5'b0;
`ifdef KEY_AUTOREPEAT_EN
    exp_sec = 4;
`else
    exp_sec = 1;
`endif
    check("t6_hold_up", 32'(bus.OUT_EDIT), 32'(tm(10, 20, exp_sec)));
    press(5'b10010);
    check("t6_chord_val", 32'(bus.OUT_EDIT), 32'(tm(10, 20, exp_sec)));
    check("t6_chord_mode", 32'(bus.MODE), 4);
    press(K_UP);
    check("t6_after_chord", 32'(bus.OUT_EDIT), 32'(tm(10, 20, exp_sec + 1)));

    // Reset mid-edit
    press(K_SET);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("rst_mid_mode", 32'(bus.MODE), 0);
    check("rst_mid_edit", 32'(bus.OUT_EDIT), 0);
    check("rst_mid_commit", 32'(bus.COMMIT), 0);
    check("rst_mid_en", 32'(bus.ALARM_EN), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
